// File: rtl/carbon_csr_init_seq.sv
// carbon_csr_init_seq: table-driven CSR initialisation sequencer.
// Walks ADDR_TABLE/DATA_TABLE through a CSR master after reset. The core is
// held in debug halt until every entry is written. After that a single
// run_pulse is issued. Failing entries are retried up to MAX_RETRY times.
// Optional read-back verification is built when CARBON_CSR_INIT_VERIFY_EN
// is defined.
module carbon_csr_init_seq #(
    parameter int unsigned               N_ENTRIES      = 2,
    parameter logic [N_ENTRIES*32-1:0]   ADDR_TABLE     = '0,
    parameter logic [N_ENTRIES*32-1:0]   DATA_TABLE     = '0,
    parameter logic [1:0]                PRIV           = 2'd1,
    parameter int unsigned               MAX_RETRY      = 2,
    parameter int unsigned               TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        m_start,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic [1:0]  m_priv,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic        m_fault,
    input  logic [31:0] m_rdata,
    output logic        halt_req,
    output logic        run_pulse,
    output logic        init_done,
    output logic        init_error,
    output logic [3:0]  err_index
);

    localparam logic [3:0] LAST_IDX = 4'(N_ENTRIES - 1);
    localparam logic [2:0] MAX_R    = 3'(MAX_RETRY);
    localparam logic [7:0] TMO      = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_DONE,
        S_ERROR
`ifdef CARBON_CSR_INIT_VERIFY_EN
        , S_VISSUE,
        S_VWAIT
`endif
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [2:0]  retry;
    logic [7:0]  timer;

    // Tables are padded to 16 slots so a 4-bit idx indexes them exactly.
    logic [31:0] addr_tab [16];
    logic [31:0] data_tab [16];

    for (genvar g = 0; g < 16; g++) begin : g_tab
        if (g < N_ENTRIES) begin : g_used
            assign addr_tab[g] = ADDR_TABLE[32*g +: 32];
            assign data_tab[g] = DATA_TABLE[32*g +: 32];
        end else begin : g_pad
            assign addr_tab[g] = '0;
            assign data_tab[g] = '0;
        end
    end

    assign m_addr  = addr_tab[idx];
    assign m_wdata = data_tab[idx];
    assign m_wstrb = 4'hF;
    assign m_priv  = PRIV;

`ifdef CARBON_CSR_INIT_VERIFY_EN
    assign m_write = (state != S_VISSUE) && (state != S_VWAIT);
`else
    logic unused_rdata;
    assign m_write      = 1'b1;
    assign unused_rdata = ^m_rdata;
`endif

    // Sequencer: issue, wait/retry per entry, then release or trap on error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_ISSUE;
            idx        <= '0;
            retry      <= '0;
            timer      <= '0;
            m_start    <= 1'b0;
            halt_req   <= 1'b1;
            run_pulse  <= 1'b0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
            err_index  <= '0;
        end else begin
            m_start   <= 1'b0;
            run_pulse <= 1'b0;
            case (state)
                S_ISSUE: begin
                    if (!m_busy) begin
                        m_start <= 1'b1;
                        timer   <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (timer != 8'hFF) timer <= timer + 8'd1;
                    if (m_done && !m_fault) begin
`ifdef CARBON_CSR_INIT_VERIFY_EN
                        state <= S_VISSUE;
`else
                        if (idx == LAST_IDX) begin
                            state <= S_RELEASE;
                        end else begin
                            idx   <= idx + 4'd1;
                            retry <= '0;
                            state <= S_ISSUE;
                        end
`endif
                    end else if (m_done || (timer == TMO)) begin
                        if (retry < MAX_R) begin
                            retry <= retry + 3'd1;
                            state <= S_ISSUE;
                        end else begin
                            init_error <= 1'b1;
                            err_index  <= idx;
                            state      <= S_ERROR;
                        end
                    end
                end
`ifdef CARBON_CSR_INIT_VERIFY_EN
                S_VISSUE: begin
                    if (!m_busy) begin
                        m_start <= 1'b1;
                        timer   <= '0;
                        state   <= S_VWAIT;
                    end
                end
                S_VWAIT: begin
                    if (timer != 8'hFF) timer <= timer + 8'd1;
                    if (m_done && !m_fault && (m_rdata == data_tab[idx])) begin
                        if (idx == LAST_IDX) begin
                            state <= S_RELEASE;
                        end else begin
                            idx   <= idx + 4'd1;
                            retry <= '0;
                            state <= S_ISSUE;
                        end
                    end else if (m_done || (timer == TMO)) begin
                        // A bad read-back costs a retry and rewrites the entry.
                        if (retry < MAX_R) begin
                            retry <= retry + 3'd1;
                            state <= S_ISSUE;
                        end else begin
                            init_error <= 1'b1;
                            err_index  <= idx;
                            state      <= S_ERROR;
                        end
                    end
                end
`endif
                S_RELEASE: begin
                    halt_req  <= 1'b0;
                    run_pulse <= 1'b1;
                    init_done <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE, S_ERROR: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_carbon_csr_init_seq.sv
// Self-checking bench for carbon_csr_init_seq: a CSR-master responder driven
// by an outcome plan, a transaction-level reference model, directed vectors
// and randomized plans.
`timescale 1ns/1ps
module tb_carbon_csr_init_seq;

    localparam int unsigned N    = 2;
    localparam int unsigned MAXR = 2;
    localparam int unsigned TMO  = 20;
    localparam logic [63:0] ADDRS = {32'h0000_0020, 32'h0000_0010};
    localparam logic [63:0] DATAS = {32'h0000_0007, 32'h0000_0000};
`ifdef CARBON_CSR_INIT_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    typedef enum int {O_OK, O_FAULT, O_TO, O_BAD} outc_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        int unsigned t;
    } txn_t;
    typedef struct {
        logic [15:0] plan;
        int unsigned len;
        bit          done;
        bit          err;
        int unsigned eidx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_start, m_write;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_priv;
    logic        m_busy = 1'b0, m_done = 1'b0, m_fault = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        halt_req, run_pulse, init_done, init_error;
    logic [3:0]  err_index;

    int tests = 0;
    int fails = 0;

    logic [31:0] ta [2] = '{32'h10, 32'h20};
    logic [31:0] td [2] = '{32'h0, 32'h7};

    outc_t       plan[$];
    txn_t        got[$];
    txn_t        exp_q[$];
    bit          exp_done, exp_err;
    int unsigned exp_eidx;
    int unsigned pk = 0, cyc = 0, run_cnt = 0, rel = 0;
    logic        force_busy = 1'b0, pend = 1'b0, cwrite = 1'b1;
    logic [31:0] caddr = '0;
    int          cd = 0;
    outc_t       kind = O_OK;
    vec_t        vecs[7];

    carbon_csr_init_seq #(
        .N_ENTRIES(N),
        .ADDR_TABLE(ADDRS),
        .DATA_TABLE(DATAS),
        .PRIV(2'd1),
        .MAX_RETRY(MAXR),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_start(m_start), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_priv(m_priv),
        .m_busy(m_busy), .m_done(m_done), .m_fault(m_fault), .m_rdata(m_rdata),
        .halt_req(halt_req), .run_pulse(run_pulse), .init_done(init_done),
        .init_error(init_error), .err_index(err_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lookup(input logic [31:0] a);
        return (a == ta[1]) ? td[1] : td[0];
    endfunction

    // Responder and monitor: sample DUT at negedge, then drive master replies.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (run_pulse) run_cnt++;
            if (m_done) begin
                m_done  = 1'b0;
                m_fault = 1'b0;
            end
            if (m_start) begin
                check("start_while_busy", {31'b0, m_busy}, 32'd0);
                got.push_back('{m_addr, m_wdata, m_write, cyc});
                kind = (pk < plan.size()) ? plan[pk] : O_OK;
                pk++;
                cwrite = m_write;
                caddr  = m_addr;
                if (kind == O_TO) begin
                    pend = 1'b0;
                    cd   = 0;
                end else begin
                    pend = 1'b1;
                    cd   = int'($urandom_range(1, 6));
                end
            end else if (pend) begin
                cd--;
                if (cd == 0) begin
                    m_done  = 1'b1;
                    m_fault = (kind == O_FAULT);
                    pend    = 1'b0;
                    m_rdata = cwrite ? $urandom : (lookup(caddr) ^ ((kind == O_BAD) ? 32'h1 : 32'h0));
                end
            end
            m_busy = force_busy | pend;
        end
    end

    // Transaction-level model: walk the plan one master transaction at a time.
    function automatic void run_model();
        int unsigned idx = 0, r = 0, k = 0;
        bit vph = 1'b0, fin = 1'b0, ok;
        outc_t o;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_eidx = 0;
        while (!fin) begin
            o = (k < plan.size()) ? plan[k] : O_OK;
            k++;
            exp_q.push_back('{ta[idx], td[idx], !vph, 0});
            ok = (o == O_OK) || (o == O_BAD && !vph);
            if (ok && VERIFY && !vph) begin
                vph = 1'b1;
            end else if (ok) begin
                vph = 1'b0;
                if (idx == N - 1) begin
                    exp_done = 1'b1;
                    fin = 1'b1;
                end else begin
                    idx++;
                    r = 0;
                end
            end else begin
                vph = 1'b0;
                if (r < MAXR) r++;
                else begin
                    exp_err  = 1'b1;
                    exp_eidx = idx;
                    fin = 1'b1;
                end
            end
        end
    endfunction

    task automatic start_run(input int unsigned busy_hold);
        @(negedge clk); #1;
        rst_n = 1'b0;
        pend = 1'b0; m_done = 1'b0; m_fault = 1'b0; cd = 0;
        force_busy = (busy_hold != 0);
        m_busy = force_busy;
        got.delete();
        pk = 0;
        @(negedge clk); @(negedge clk); #1;
        run_cnt = 0;
        rst_n = 1'b1;
        rel = cyc;
        if (busy_hold != 0) begin
            while (cyc < rel + busy_hold) begin
                @(negedge clk); #1;
            end
            force_busy = 1'b0;
            m_busy = pend;
        end
    endtask

    task automatic wait_end();
        int unsigned n = 0;
        while (!(init_done || init_error) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        check("terminate", {31'b0, init_done | init_error}, 32'd1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic compare_run(input string tag);
        run_model();
        check({tag, "_nstarts"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check({tag, "_addr"}, got[i].a, exp_q[i].a);
            check({tag, "_wdata"}, got[i].d, exp_q[i].d);
            check({tag, "_write"}, {31'b0, got[i].w}, {31'b0, exp_q[i].w});
        end
        check({tag, "_done"}, {31'b0, init_done}, {31'b0, exp_done});
        check({tag, "_error"}, {31'b0, init_error}, {31'b0, exp_err});
        check({tag, "_err_index"}, {28'b0, err_index}, exp_eidx);
        check({tag, "_halt"}, {31'b0, halt_req}, {31'b0, !exp_done});
        check({tag, "_run_pulses"}, run_cnt, exp_done ? 32'd1 : 32'd0);
    endtask

    task automatic load_plan(input logic [15:0] bits, input int unsigned len);
        logic [15:0] tmp;
        tmp = bits;
        plan.delete();
        for (int i = 0; i < len; i++) plan.push_back(outc_t'(int'(tmp[2*i +: 2])));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned len, gap;
        // plan codes: 0 ok, 1 fault, 2 timeout, 3 corrupt read-back
        vecs[0] = '{16'h0000, 0, 1'b1, 1'b0, 0};
        vecs[1] = '{16'h0004, 2, 1'b1, 1'b0, 0};
        vecs[2] = '{16'h0015, 3, 1'b0, 1'b1, 0};
        vecs[3] = '{16'h002A, 3, 1'b0, 1'b1, 0};
        vecs[4] = '{16'h0009, 3, 1'b1, 1'b0, 0};
        vecs[5] = '{16'h0020, 3, 1'b1, 1'b0, 0};
        vecs[6] = '{16'h00C0, 4, 1'b1, 1'b0, 0};

        // reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_m_start", {31'b0, m_start}, 32'd0);
        check("rst_halt", {31'b0, halt_req}, 32'd1);
        check("rst_run_pulse", {31'b0, run_pulse}, 32'd0);
        check("rst_done", {31'b0, init_done}, 32'd0);
        check("rst_error", {31'b0, init_error}, 32'd0);
        check("rst_err_index", {28'b0, err_index}, 32'd0);
        check("rst_addr", m_addr, 32'h10);
        check("rst_write", {31'b0, m_write}, 32'd1);
        check("wstrb", {28'b0, m_wstrb}, 32'hF);
        check("priv", {30'b0, m_priv}, 32'd1);

        // directed vectors
        for (int v = 0; v < 7; v++) begin
            load_plan(vecs[v].plan, vecs[v].len);
            start_run(0);
            wait_end();
            check("vec_done", {31'b0, init_done}, {31'b0, vecs[v].done});
            check("vec_error", {31'b0, init_error}, {31'b0, vecs[v].err});
            check("vec_err_index", {28'b0, err_index}, vecs[v].eidx);
            if (got.size() > 0) check("vec_first_start_latency", got[0].t - rel, 32'd1);
            else check("vec_any_start", 32'd0, 32'd1);
            compare_run("vec");
            if (v == 3) begin
                check("to_nstarts", got.size(), 32'd3);
                for (int i = 1; i < got.size(); i++) begin
                    gap = got[i].t - got[i-1].t;
                    check("to_gap_min21", {31'b0, gap >= 21}, 32'd1);
                end
            end
        end

        // spurious m_done in DONE is ignored
        load_plan(16'h0, 0);
        start_run(0);
        wait_end();
        len = got.size();
        m_done = 1'b1;
        m_fault = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("done_ignore_starts", got.size(), len);
        check("done_ignore_run", run_cnt, 32'd1);
        check("done_ignore_done", {31'b0, init_done}, 32'd1);

        // busy held for 10 cycles after reset release
        load_plan(16'h0, 0);
        start_run(10);
        wait_end();
        if (got.size() > 0) check("busy_first_start", got[0].t - rel, 32'd11);
        else check("busy_any_start", 32'd0, 32'd1);
        compare_run("busy");

        // reset during WAIT of entry 1
        load_plan(16'h0020, 3);
        start_run(0);
        for (int n = 0; n < 200 && got.size() < 2; n++) begin
            @(negedge clk); #1;
        end
        check("midrst_reached_e1", got.size(), 32'd2);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_m_start", {31'b0, m_start}, 32'd0);
        check("midrst_halt", {31'b0, halt_req}, 32'd1);
        check("midrst_run_pulse", {31'b0, run_pulse}, 32'd0);
        check("midrst_done", {31'b0, init_done}, 32'd0);
        check("midrst_error", {31'b0, init_error}, 32'd0);
        check("midrst_addr", m_addr, 32'h10);
        load_plan(16'h0, 0);
        start_run(0);
        wait_end();
        if (got.size() > 0) check("midrst_restart_addr", got[0].a, 32'h10);
        compare_run("midrst");

        // randomized plans against the model
        for (int it = 0; it < 25; it++) begin
            int unsigned r;
            plan.delete();
            len = $urandom_range(0, 7);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                plan.push_back(r <= 5 ? O_OK : r <= 7 ? O_FAULT : r == 8 ? O_TO : O_BAD);
            end
            start_run($urandom_range(0, 3));
            wait_end();
            compare_run("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
